// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-bank widths and the writeback entry type
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] register;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_fifo.sv
// rtl/writeback_queue_fifo.sv - entry storage and pointers for the writeback queue
// WRITEBACK_QUEUE_BYPASS_EN exposes the storage and read pointer for the bypass match.
module writeback_queue_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  wb_entry_t     push_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count
`ifdef WRITEBACK_QUEUE_BYPASS_EN
  ,
  output wb_entry_t     entries [DEPTH],
  output logic [PW-1:0] head_ptr
`endif
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  assign entries  = mem;
  assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - register writeback queue with output stage and r0 filter
// WRITEBACK_QUEUE_BYPASS_EN adds the combinational query_register/query_hit/query_data port.
module writeback_queue
  import mips_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_register,
  input  logic [31:0]   in_data,
  input  logic          hold,
  output logic          reg_write,
  output logic [4:0]    write_register,
  output logic [31:0]   write_data,
  output logic [CW-1:0] count
`ifdef WRITEBACK_QUEUE_BYPASS_EN
  ,
  input  logic [4:0]    query_register,
  output logic          query_hit,
  output logic [31:0]   query_data
`endif
);

  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  wb_entry_t     push_entry;
  wb_entry_t     head;

  // Writes to r0 complete the handshake but never reach the register bank.
  assign accept     = in_valid && in_ready;
  assign push       = accept && (in_register != '0);
  assign pop        = !hold && (count != '0);
  assign push_entry = '{register: in_register, data: in_data};

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  localparam int PW = $clog2(DEPTH);
  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] slot;
`endif

  writeback_queue_fifo #(.DEPTH(DEPTH)) fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    ,
    .entries    (entries),
    .head_ptr   (head_ptr)
`endif
  );

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // in_ready comes from a flop so a pop on a full queue cannot open it mid-cycle.
  always_ff @(posedge clock) begin
    if (reset) in_ready <= 1'b1;
    else       in_ready <= (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else if (pop) begin
      reg_write      <= 1'b1;
      write_register <= head.register;
      write_data     <= head.data;
    end else begin
      reg_write      <= 1'b0;
    end
  end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  // Scan oldest to newest so the tail-most match overrides earlier ones.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    slot       = '0;
    if (query_register != '0) begin
      if (reg_write && (write_register == query_register)) begin
        query_hit  = 1'b1;
        query_data = write_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        slot = head_ptr + PW'(i);
        if ((i < int'(count)) && (entries[slot].register == query_register)) begin
          query_hit  = 1'b1;
          query_data = entries[slot].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
// Define WRITEBACK_QUEUE_BYPASS_EN to also exercise the query port.
module tb_writeback_queue;
  import mips_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_register;
  logic [31:0] in_data;
  logic        hold;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [2:0]  count;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
  logic [4:0]  query_register;
  logic        query_hit;
  logic [31:0] query_data;
`endif

  int        n_checks = 0;
  int        n_pass   = 0;
  int        n_writes = 0;
  int        writes_before;
  wb_entry_t exp_q[$];
  wb_entry_t mon_entry;

  writeback_queue #(.DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_register    (in_register),
    .in_data        (in_data),
    .hold           (hold),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .count          (count)
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    ,
    .query_register (query_register),
    .query_hit      (query_hit),
    .query_data     (query_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Expected entry is queued before the accept edge; r0 writes never appear.
  task automatic send(input logic [4:0] r, input logic [31:0] d);
    bit done;
    done        = 1'b0;
    in_valid    = 1'b1;
    in_register = r;
    in_data     = d;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready === 1'b1 && !reset) begin
        if (r != 5'd0) exp_q.push_back('{register: r, data: d});
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  always @(posedge clock) begin
    #1;
    if (reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_entry = exp_q.pop_front();
        check("wb_register", 32'(write_register), 32'(mon_entry.register));
        check("wb_data", write_data, mon_entry.data);
        n_writes++;
      end
    end
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_register = '0;
    in_data     = '0;
    hold        = 1'b0;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    query_register = '0;
`endif
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_write_register", 32'(write_register), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    reset = 1'b0;
    tick();

    // single write: visible exactly one cycle after the accept edge
    send(5'd5, 32'h0000_00AA);
    check("lat_accept_reg_write", 32'(reg_write), 32'd0);
    check("lat_accept_count", 32'(count), 32'd1);
    tick();
    check("lat_reg_write", 32'(reg_write), 32'd1);
    check("lat_write_register", 32'(write_register), 32'd5);
    check("lat_write_data", write_data, 32'h0000_00AA);
    tick();
    check("lat_after_reg_write", 32'(reg_write), 32'd0);

    // fill under hold, refuse a fifth, then drain in order
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) send(5'(i), 32'h1000 + 32'(i));
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid    = 1'b1;
    in_register = 5'd9;
    in_data     = 32'h9999;
    repeat (2) begin
      tick();
      check("full_reject_ready", 32'(in_ready), 32'd0);
      check("full_reject_count", 32'(count), 32'd4);
      check("full_hold_reg_write", 32'(reg_write), 32'd0);
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_reg_write", 32'(reg_write), 32'd1);
      check("drain_order", 32'(write_register), 32'(i));
    end
    tick();
    check("drain_done_reg_write", 32'(reg_write), 32'd0);
    check("drain_done_count", 32'(count), 32'd0);

    // r0 write is consumed and dropped
    writes_before = n_writes;
    send(5'd0, 32'hDEAD_BEEF);
    check("r0_count", 32'(count), 32'd0);
    repeat (3) begin
      tick();
      check("r0_no_write", 32'(reg_write), 32'd0);
    end

    // ten back-to-back pushes across pointer wrap
    writes_before = n_writes;
    for (int i = 0; i < 10; i++) send(5'((i % 31) + 1), 32'h0100 + 32'(i));
    check("b2b_steady_count", 32'(count), 32'd1);
    repeat (4) tick();
    check("b2b_writes", 32'(n_writes - writes_before), 32'd10);
    check("b2b_count", 32'(count), 32'd0);

    // reset with entries queued, plus a push presented during reset
    hold = 1'b1;
    for (int i = 0; i < 3; i++) send(5'(10 + i), 32'h2000 + 32'(i));
    check("rst3_count", 32'(count), 32'd3);
    reset       = 1'b1;
    hold        = 1'b0;
    in_valid    = 1'b1;
    in_register = 5'd6;
    in_data     = 32'h6666;
    exp_q.delete();
    tick();
    check("rst3_count_after", 32'(count), 32'd0);
    check("rst3_reg_write", 32'(reg_write), 32'd0);
    check("rst3_in_ready", 32'(in_ready), 32'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    writes_before = n_writes;
    repeat (5) tick();
    check("rst3_no_stale", 32'(n_writes - writes_before), 32'd0);
    check("rst3_count_idle", 32'(count), 32'd0);

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    hold = 1'b1;
    send(5'd7, 32'd1);
    send(5'd7, 32'd2);
    query_register = 5'd7;
    #1;
    check("byp_hit", 32'(query_hit), 32'd1);
    check("byp_data", query_data, 32'd2);
    query_register = 5'd0;
    #1;
    check("byp_r0_miss", 32'(query_hit), 32'd0);
    hold = 1'b0;
    repeat (4) tick();
`endif

    repeat (2) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
